// File: rtl/vend_ctrl_multi.sv
// Multi-channel vending controller: coin credit, item selection, dispense handshake, unit-by-unit change.
// Every output is a register; reactions to inputs appear one cycle later.
module vend_ctrl_multi #(
  parameter int N_ITEMS    = 4,
  parameter int CREDIT_W   = 6,
  parameter int PRICE      = 4,
  parameter int MAX_CREDIT = 15
) (
  input  logic                       CLK50M,
  input  logic                       RSTb,
  input  logic                       coin_valid,
  input  logic [1:0]                 coin_sel,
  input  logic                       sel_valid,
  input  logic [$clog2(N_ITEMS)-1:0] sel_item,
  input  logic                       cancel,
  input  logic [N_ITEMS-1:0]         stock_empty,
  input  logic                       vend_ack,
  input  logic                       chg_ack,
  output logic [N_ITEMS-1:0]         vend,
  output logic                       chg_req,
  output logic [CREDIT_W-1:0]        credit,
  output logic [1:0]                 state,
  output logic                       busy,
  output logic                       coin_reject,
  output logic                       sel_reject
);

  if (N_ITEMS < 2 || N_ITEMS > 16 || PRICE > MAX_CREDIT || MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_params
    $error("vend_ctrl_multi: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  localparam logic [N_ITEMS-1:0] ONE_HOT0 = N_ITEMS'(1);

  state_t            st;
  logic [CREDIT_W:0] coin_val;
  logic [CREDIT_W:0] coin_sum;
  logic              coin_fits;
  logic              sel_ok;

  assign state = st;

  always_comb begin
    coin_val  = (CREDIT_W+1)'(1) << coin_sel;
    coin_sum  = {1'b0, credit} + coin_val;
    coin_fits = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    sel_ok    = (int'(sel_item) < N_ITEMS) && !stock_empty[sel_item] &&
                (credit >= CREDIT_W'(PRICE));
  end

  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      st          <= S_IDLE;
      credit      <= '0;
      vend        <= '0;
      chg_req     <= 1'b0;
      busy        <= 1'b0;
      coin_reject <= 1'b0;
      sel_reject  <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      sel_reject  <= 1'b0;
      case (st)
        S_IDLE: begin
          sel_reject <= sel_valid;
          if (coin_valid) begin
            if (coin_fits) begin
              credit <= coin_sum[CREDIT_W-1:0];
              st     <= S_CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end
        S_CREDIT: begin
          // Same-cycle priority: cancel, then coin, then selection.
          if (cancel) begin
            st          <= S_CHANGE;
            busy        <= 1'b1;
            chg_req     <= 1'b1;
            coin_reject <= coin_valid;
            sel_reject  <= sel_valid;
          end else if (coin_valid) begin
            if (coin_fits) credit <= coin_sum[CREDIT_W-1:0];
            else           coin_reject <= 1'b1;
            sel_reject <= sel_valid;
          end else if (sel_valid) begin
            if (sel_ok) begin
              credit <= credit - CREDIT_W'(PRICE);
              vend   <= ONE_HOT0 << sel_item;
              st     <= S_VEND;
              busy   <= 1'b1;
            end else begin
              sel_reject <= 1'b1;
            end
          end
        end
        S_VEND: begin
          coin_reject <= coin_valid;
          sel_reject  <= sel_valid;
          if (vend_ack) begin
            vend <= '0;
            if (credit != '0) begin
              st      <= S_CHANGE;
              chg_req <= 1'b1;
            end else begin
              st   <= S_IDLE;
              busy <= 1'b0;
            end
          end
        end
        S_CHANGE: begin
          coin_reject <= coin_valid;
          sel_reject  <= sel_valid;
          // chg_req low marks the mandatory gap cycle between paid units.
          if (chg_req) begin
            if (chg_ack) begin
              credit  <= credit - CREDIT_W'(1);
              chg_req <= 1'b0;
            end
          end else if (credit != '0) begin
            chg_req <= 1'b1;
          end else begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Bench for vend_ctrl_multi: directed vector table, hand-written reset/change sequences, random run vs model.
module tb_vend_ctrl_multi;
  localparam int N_ITEMS    = 4;
  localparam int CREDIT_W   = 6;
  localparam int PRICE      = 4;
  localparam int MAX_CREDIT = 15;

  logic                CLK50M = 1'b0;
  logic                RSTb   = 1'b0;
  logic                coin_valid = 1'b0;
  logic [1:0]          coin_sel = 2'd0;
  logic                sel_valid = 1'b0;
  logic [1:0]          sel_item = 2'd0;
  logic                cancel = 1'b0;
  logic [N_ITEMS-1:0]  stock_empty = '0;
  logic                vend_ack = 1'b0;
  logic                chg_ack = 1'b0;
  logic [N_ITEMS-1:0]  vend;
  logic                chg_req;
  logic [CREDIT_W-1:0] credit;
  logic [1:0]          state;
  logic                busy;
  logic                coin_reject;
  logic                sel_reject;

  int total = 0;
  int bad   = 0;

  vend_ctrl_multi #(
    .N_ITEMS(N_ITEMS), .CREDIT_W(CREDIT_W), .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT)
  ) dut (
    .CLK50M(CLK50M), .RSTb(RSTb), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel), .stock_empty(stock_empty),
    .vend_ack(vend_ack), .chg_ack(chg_ack), .vend(vend), .chg_req(chg_req), .credit(credit),
    .state(state), .busy(busy), .coin_reject(coin_reject), .sel_reject(sel_reject)
  );

  always #5 CLK50M = ~CLK50M;

  typedef struct {
    logic       rst;
    logic       cv;  logic [1:0] cs;
    logic       sv;  logic [1:0] si;
    logic       cn;  logic [3:0] se;
    logic       va;  logic       ca;
    logic [1:0] st;  logic [5:0] cr; logic [3:0] vd;
    logic       cq;  logic       crj; logic      srj;
  } row_t;

  row_t rows[$];

  // Packed observation: {vend, chg_req, credit, state, busy, coin_reject, sel_reject}
  function automatic logic [15:0] obs();
    return {vend, chg_req, credit, state, busy, coin_reject, sel_reject};
  endfunction

  function automatic logic [15:0] pack(logic [3:0] vd, logic cq, logic [5:0] cr, logic [1:0] st,
                                       logic crj, logic srj);
    return {vd, cq, cr, st, (st >= 2'd2), crj, srj};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK50M);
    #1;
  endtask

  task automatic idle_inputs();
    coin_valid = 0; coin_sel = 0; sel_valid = 0; sel_item = 0;
    cancel = 0; stock_empty = '0; vend_ack = 0; chg_ack = 0;
  endtask

  task automatic pulse_reset();
    RSTb = 1'b0;
    #2;
    RSTb = 1'b1;
  endtask

  function automatic row_t mk(logic rst, logic cv, logic [1:0] cs, logic sv, logic [1:0] si,
                              logic cn, logic [3:0] se, logic va, logic ca, logic [1:0] st,
                              logic [5:0] cr, logic [3:0] vd, logic cq, logic crj, logic srj);
    row_t r;
    r.rst = rst; r.cv = cv; r.cs = cs; r.sv = sv; r.si = si; r.cn = cn; r.se = se;
    r.va = va; r.ca = ca; r.st = st; r.cr = cr; r.vd = vd; r.cq = cq; r.crj = crj; r.srj = srj;
    return r;
  endfunction

  // Reference model: credit is a number, "vending" is the item index (or -1),
  // change payout is 0 = not paying, 1 = requesting a unit, 2 = gap after a unit.
  int m_credit, m_vend_item, m_pay;
  logic m_crj, m_srj;

  task automatic model_reset();
    m_credit = 0; m_vend_item = -1; m_pay = 0; m_crj = 0; m_srj = 0;
  endtask

  task automatic model_step();
    int cv;
    m_crj = 0;
    m_srj = 0;
    cv = 1 << coin_sel;
    if (m_vend_item >= 0) begin
      m_crj = coin_valid; m_srj = sel_valid;
      if (vend_ack) begin
        m_vend_item = -1;
        if (m_credit > 0) m_pay = 1;
      end
    end else if (m_pay != 0) begin
      m_crj = coin_valid; m_srj = sel_valid;
      if (m_pay == 1) begin
        if (chg_ack) begin m_credit--; m_pay = 2; end
      end else begin
        m_pay = (m_credit > 0) ? 1 : 0;
      end
    end else if (cancel && m_credit > 0) begin
      m_pay = 1; m_crj = coin_valid; m_srj = sel_valid;
    end else if (coin_valid) begin
      if (m_credit + cv > MAX_CREDIT) m_crj = 1;
      else m_credit += cv;
      m_srj = sel_valid;
    end else if (sel_valid) begin
      if (m_credit >= PRICE && !stock_empty[sel_item] && int'(sel_item) < N_ITEMS) begin
        m_credit -= PRICE;
        m_vend_item = int'(sel_item);
      end else begin
        m_srj = 1;
      end
    end
  endtask

  function automatic logic [15:0] model_obs();
    logic [1:0] st;
    logic [3:0] vd;
    st = (m_vend_item >= 0) ? 2'd2 : (m_pay != 0) ? 2'd3 : (m_credit > 0) ? 2'd1 : 2'd0;
    vd = (m_vend_item >= 0) ? 4'(1 << m_vend_item) : 4'd0;
    return pack(vd, (m_pay == 1), 6'(m_credit), st, m_crj, m_srj);
  endfunction

  initial begin
    // rst cv cs sv si cn se va ca | st cr vd cq crj srj
    rows.push_back(mk(1, 0,0, 1,2, 0,4'h0, 0,0, 0, 0,4'b0000, 0,0,1)); // sel in IDLE
    rows.push_back(mk(0, 0,0, 0,0, 1,4'h0, 0,0, 0, 0,4'b0000, 0,0,0)); // cancel in IDLE
    rows.push_back(mk(0, 1,2, 0,0, 0,4'h0, 0,0, 1, 4,4'b0000, 0,0,0));
    rows.push_back(mk(0, 0,0, 1,1, 0,4'h0, 0,0, 2, 0,4'b0010, 0,0,0));
    rows.push_back(mk(0, 1,0, 0,0, 0,4'h0, 0,0, 2, 0,4'b0010, 0,1,0)); // coin in VEND
    rows.push_back(mk(0, 0,0, 0,0, 0,4'h0, 1,0, 0, 0,4'b0000, 0,0,0));
    rows.push_back(mk(0, 0,0, 0,0, 0,4'h0, 1,1, 0, 0,4'b0000, 0,0,0)); // stray acks
    rows.push_back(mk(0, 1,3, 0,0, 0,4'h0, 0,0, 1, 8,4'b0000, 0,0,0));
    rows.push_back(mk(0, 0,0, 1,0, 0,4'h0, 0,0, 2, 4,4'b0001, 0,0,0));
    rows.push_back(mk(0, 0,0, 0,0, 0,4'h0, 1,0, 3, 4,4'b0000, 1,0,0));
    rows.push_back(mk(0, 0,0, 1,0, 0,4'h0, 0,0, 3, 4,4'b0000, 1,0,1)); // sel in CHANGE
    rows.push_back(mk(0, 0,0, 0,0, 0,4'h0, 0,1, 3, 3,4'b0000, 0,0,0));
    rows.push_back(mk(0, 0,0, 0,0, 0,4'h0, 0,1, 3, 3,4'b0000, 1,0,0)); // ack during gap
    rows.push_back(mk(0, 0,0, 0,0, 0,4'h0, 0,1, 3, 2,4'b0000, 0,0,0));
    rows.push_back(mk(0, 0,0, 0,0, 0,4'h0, 0,0, 3, 2,4'b0000, 1,0,0));
    rows.push_back(mk(0, 0,0, 0,0, 0,4'h0, 0,1, 3, 1,4'b0000, 0,0,0));
    rows.push_back(mk(0, 0,0, 0,0, 0,4'h0, 0,0, 3, 1,4'b0000, 1,0,0));
    rows.push_back(mk(0, 0,0, 0,0, 0,4'h0, 0,1, 3, 0,4'b0000, 0,0,0));
    rows.push_back(mk(0, 0,0, 0,0, 0,4'h0, 0,1, 0, 0,4'b0000, 0,0,0));
    rows.push_back(mk(1, 1,3, 0,0, 0,4'h0, 0,0, 1, 8,4'b0000, 0,0,0));
    rows.push_back(mk(0, 1,2, 0,0, 0,4'h0, 0,0, 1,12,4'b0000, 0,0,0));
    rows.push_back(mk(0, 1,2, 0,0, 0,4'h0, 0,0, 1,12,4'b0000, 0,1,0)); // overflow coin
    rows.push_back(mk(0, 1,0, 1,0, 0,4'h0, 0,0, 1,13,4'b0000, 0,0,1)); // coin beats sel
    rows.push_back(mk(1, 1,1, 0,0, 0,4'h0, 0,0, 1, 2,4'b0000, 0,0,0));
    rows.push_back(mk(0, 0,0, 1,0, 0,4'h0, 0,0, 1, 2,4'b0000, 0,0,1)); // short credit
    rows.push_back(mk(0, 1,1, 0,0, 0,4'h0, 0,0, 1, 4,4'b0000, 0,0,0));
    rows.push_back(mk(0, 0,0, 1,3, 0,4'h8, 0,0, 1, 4,4'b0000, 0,0,1)); // empty channel
    rows.push_back(mk(0, 0,0, 1,2, 0,4'h8, 0,0, 2, 0,4'b0100, 0,0,0));
    rows.push_back(mk(0, 0,0, 0,0, 0,4'h0, 1,0, 0, 0,4'b0000, 0,0,0));
    rows.push_back(mk(1, 1,2, 0,0, 0,4'h0, 0,0, 1, 4,4'b0000, 0,0,0));
    rows.push_back(mk(0, 1,1, 0,0, 0,4'h0, 0,0, 1, 6,4'b0000, 0,0,0));
    rows.push_back(mk(0, 1,0, 1,1, 1,4'h0, 0,0, 3, 6,4'b0000, 1,1,1)); // cancel beats all

    #1;
    check("reset_async", 32'(obs()), 32'(16'h0000));
    #20;
    RSTb = 1'b1;
    step();

    foreach (rows[i]) begin
      if (rows[i].rst) pulse_reset();
      coin_valid = rows[i].cv; coin_sel = rows[i].cs; sel_valid = rows[i].sv;
      sel_item = rows[i].si; cancel = rows[i].cn; stock_empty = rows[i].se;
      vend_ack = rows[i].va; chg_ack = rows[i].ca;
      step();
      check($sformatf("row%0d", i), 32'(obs()),
            32'(pack(rows[i].vd, rows[i].cq, rows[i].cr, rows[i].st, rows[i].crj, rows[i].srj)));
    end

    // Six change units from credit 6, with the gap cycle between each.
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      chg_ack = 1;
      step();
      check($sformatf("pay%0d_ack", i), 32'({chg_req, credit, state}), 32'({1'b0, 6'(5 - i), 2'd3}));
      chg_ack = 0;
      step();
      check($sformatf("pay%0d_gap", i), 32'({chg_req, state}),
            32'({(i < 5), (i < 5) ? 2'd3 : 2'd0}));
    end

    // Asynchronous reset in the middle of a change payout.
    coin_valid = 1; coin_sel = 2; step();
    coin_sel = 0; step();
    coin_valid = 0; cancel = 1; step();
    cancel = 0;
    check("pre_rst_change", 32'({chg_req, credit, state}), 32'({1'b1, 6'd5, 2'd3}));
    #3;
    RSTb = 1'b0;
    #1;
    check("rst_mid_change", 32'(obs()), 32'(16'h0000));
    step(); step();
    RSTb = 1'b1;
    chg_ack = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post_rst%0d", i), 32'({chg_req, credit, state}), 32'(0));
    end
    chg_ack = 0;

    // Reset during VEND discards credit; next coin starts fresh from IDLE.
    coin_valid = 1; coin_sel = 3; step();
    coin_valid = 0; sel_valid = 1; sel_item = 0; step();
    sel_valid = 0;
    check("pre_rst_vend", 32'({vend, credit, state}), 32'({4'b0001, 6'd4, 2'd2}));
    pulse_reset();
    check("rst_mid_vend", 32'(obs()), 32'(16'h0000));
    coin_valid = 1; coin_sel = 1; step();
    coin_valid = 0;
    check("after_rst_vend", 32'(obs()), 32'(pack(4'b0000, 0, 6'd2, 2'd1, 0, 0)));

    // Randomized run against the reference model.
    idle_inputs();
    pulse_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
        model_reset();
      end
      coin_valid  = ($urandom_range(0, 3) == 0);
      coin_sel    = 2'($urandom_range(0, 3));
      sel_valid   = ($urandom_range(0, 4) == 0);
      sel_item    = 2'($urandom_range(0, 3));
      cancel      = ($urandom_range(0, 24) == 0);
      stock_empty = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      vend_ack    = ($urandom_range(0, 2) == 0);
      chg_ack     = ($urandom_range(0, 1) == 0);
      model_step();
      step();
      check($sformatf("rand%0d", n), 32'(obs()), 32'(model_obs()));
    end

    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_multi.md
VEND_CTRL_MULTI -- requirements
Module: vend_ctrl_multi

Interface
REQ-001 SHALL have parameter N_ITEMS, default 4, number of product channels (2..16).
REQ-002 SHALL have parameter CREDIT_W, default 6, credit register width in coin units.
REQ-003 SHALL have parameter PRICE, default 4, item price in coin units, shared by all items.
REQ-004 SHALL have parameter MAX_CREDIT, default 15, highest credit accepted; PRICE <= MAX_CREDIT < 2^CREDIT_W, checked at elaboration.
REQ-005 CLK50M  in  1  single clock; all state changes on its rising edge.
REQ-006 RSTb  in  1  asynchronous, active-low reset.
REQ-007 coin_valid  in  1  single-cycle pulse: one coin inserted.
REQ-008 coin_sel  in  2  coin code: 0=1, 1=2, 2=4, 3=8 units; sampled with coin_valid.
REQ-009 sel_valid  in  1  single-cycle pulse: item selection.
REQ-010 sel_item  in  $clog2(N_ITEMS)  selected item index; sampled with sel_valid.
REQ-011 cancel  in  1  single-cycle pulse: refund request.
REQ-012 stock_empty  in  N_ITEMS  per-item empty flag, level.
REQ-013 vend_ack  in  1  dispenser done.
REQ-014 chg_ack  in  1  change hopper has paid one unit.
REQ-015 vend  out  N_ITEMS  one-hot dispense request.
REQ-016 chg_req  out  1  request to pay one change unit.
REQ-017 credit  out  CREDIT_W  current credit.
REQ-018 state  out  2  state code: IDLE=0, CREDIT=1, VEND=2, CHANGE=3.
REQ-019 busy  out  1  high in VEND or CHANGE.
REQ-020 coin_reject  out  1  one-cycle pulse: coin refused (returned mechanically).
REQ-021 sel_reject  out  1  one-cycle pulse: selection refused.

Function
REQ-022 SHALL register every output; no combinational input-to-output path.
REQ-023 IDLE: credit == 0; accepted coin -> CREDIT with credit = coin value; sel_valid -> sel_reject; cancel ignored.
REQ-024 CREDIT: accepted coin -> credit += value; coin with credit+value > MAX_CREDIT -> coin_reject, credit unchanged.
REQ-025 CREDIT, sel_valid, credit >= PRICE, stock_empty[sel_item]=0, sel_item < N_ITEMS -> next cycle VEND, credit -= PRICE, vend[sel_item]=1.
REQ-026 CREDIT, sel_valid otherwise -> sel_reject, state and credit unchanged.
REQ-027 CREDIT, cancel -> CHANGE (credit > 0 always holds in CREDIT).
REQ-028 Same-cycle priority in CREDIT: cancel > coin > sel; losing coin -> coin_reject, losing sel -> sel_reject.
REQ-029 VEND: hold vend one-hot until the cycle vend_ack=1; next cycle vend=0, state = CHANGE if credit > 0 else IDLE.
REQ-030 CHANGE: chg_req=1 until chg_ack=1; on ack credit -= 1 and chg_req=0 the following cycle; reassert one cycle later if credit > 0, else -> IDLE.
REQ-031 chg_req SHALL be low for >= 1 cycle between successive units; chg_ack while chg_req=0 ignored.
REQ-032 VEND and CHANGE: coin_valid -> coin_reject; sel_valid -> sel_reject; cancel ignored.
REQ-033 vend_ack outside VEND ignored; credit SHALL never underflow or exceed MAX_CREDIT.
REQ-034 busy = (state==VEND)|(state==CHANGE), registered with state.

Reset
REQ-035 RSTb=0 SHALL immediately force state=IDLE, credit=0, vend=0, chg_req=0, busy=0, coin_reject=0, sel_reject=0, regardless of clock.
REQ-036 Reset mid-VEND or mid-CHANGE SHALL discard credit; first edge after RSTb release behaves as IDLE.

Verification (PRICE=4, MAX_CREDIT=15, N_ITEMS=4)
REQ-037 Coin sel=2, then sel_item=1 -> vend=0010, credit=0, state=2; vend_ack -> state=0, vend=0.
REQ-038 Coin sel=3 (8), sel_item=0, vend_ack -> state=3, credit=4; four chg_req/chg_ack handshakes -> credit 3,2,1,0, then state=0.
REQ-039 Coins 8,4,4 -> third coin_reject pulse, credit=12, state=1.
REQ-040 Credit 2, sel_valid -> sel_reject, credit=2; credit 4 with stock_empty[3]=1, sel_item=3 -> sel_reject, no vend.
REQ-041 Credit 6, cancel and coin_valid same cycle -> coin_reject, state=3, six change units paid, state=0.
REQ-042 RSTb low during CHANGE with credit=5 -> chg_req=0, credit=0, state=0 asynchronously; no further chg_req after release.
